// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 frame sequencer: command bytes, frame
// and byte-transfer state encodings, and the display-control byte helper.
package tm1638_pkg;

  localparam logic [7:0] CMD_WRITE_AUTO = 8'h40;
  localparam logic [7:0] CMD_READ_KEYS  = 8'h42;
  localparam logic [7:0] CMD_ADDR0      = 8'hC0;
  localparam logic [7:0] CMD_DISP_CTRL  = 8'h80;

  localparam int NUM_DISP_BYTES = 16;
  localparam int NUM_KEY_BYTES  = 4;

  typedef enum logic [2:0] {IDLE, MODE, ADDR, CTRL, KEYS, GAP} frame_state_e;
  typedef enum logic [1:0] {X_IDLE, X_LATCH, X_WAIT_HI, X_WAIT_LO} xfer_state_e;

  function automatic logic [7:0] disp_ctrl_byte(input logic on, input logic [2:0] level);
    return CMD_DISP_CTRL | {4'b0000, on, level};
  endfunction

endpackage

// File: rtl/tm1638_xfer.sv
// Single-byte handshake with tm1638_sio: one-cycle latch, wait for busy to
// rise (bounded by BUSY_TIMEOUT) then fall; sticky fault on a missed rise.
module tm1638_xfer
  import tm1638_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic sio_busy,
  output logic sio_latch,
  output logic done,
  output logic fault
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  xfer_state_e   state, state_d;
  logic [CW-1:0] wait_cnt, wait_cnt_d;
  logic          timeout;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!rst) begin
      state    <= X_IDLE;
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (timeout) fault <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d    = state;
    wait_cnt_d = wait_cnt;
    sio_latch  = 1'b0;
    done       = 1'b0;
    timeout    = 1'b0;
    case (state)
      X_IDLE: if (start) state_d = X_LATCH;
      X_LATCH: begin
        sio_latch  = 1'b1;
        wait_cnt_d = '0;
        state_d    = X_WAIT_HI;
      end
      X_WAIT_HI: begin
        if (sio_busy) begin
          state_d = X_WAIT_LO;
        end else if (wait_cnt == CW'(BUSY_TIMEOUT - 1)) begin
          // Give up on the engine but finish the byte so the frame can close.
          timeout = 1'b1;
          done    = 1'b1;
          state_d = X_IDLE;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      X_WAIT_LO: begin
        if (!sio_busy) begin
          done    = 1'b1;
          state_d = X_IDLE;
        end
      end
      default: state_d = X_IDLE;
    endcase
  end

endmodule

// File: rtl/tm1638_ctrl.sv
// TM1638 frame sequencer: mode, address+16 display bytes, display control and,
// with TM1638_KEY_SCAN_EN defined, a 4-byte key-scan read, each in its own STB group.
module tm1638_ctrl
  import tm1638_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int STB_GAP      = 4,
  parameter int BUSY_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg,
  input  logic [7:0]  led,
  input  logic [2:0]  brightness,
  input  logic        display_on,
  input  logic        update,
  output logic        stb,
  output logic        sio_latch,
  output logic        sio_rw,
  output logic [7:0]  sio_wdata,
  input  logic [7:0]  sio_rdata,
  input  logic        sio_busy,
  output logic [31:0] keys,
  output logic        key_valid,
  output logic        ctrl_busy,
  output logic        fault
);

  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int GW = $clog2(STB_GAP + 1);

  frame_state_e  state, state_d, gap_ret, gap_ret_d, next_group;
  logic [4:0]    byte_idx, byte_idx_d, last_idx;
  logic [3:0]    disp_idx;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          in_flight, in_flight_d, stb_d, busy_d, start, snap, xfer_done;
  logic [7:0]    wdata_d, tx_byte;
  logic [RW-1:0] refresh_cnt;
  logic          pending, wrap;

  logic [63:0]   seg_q;
  logic [7:0]    led_q;
  logic [2:0]    bright_q;
  logic          on_q;

`ifdef TM1638_KEY_SCAN_EN
  logic [31:0]   key_shadow, key_shadow_d, keys_d;
  logic          key_valid_d, rw_d, rw_q, tx_rw;
  logic [1:0]    key_sel;
`endif

  tm1638_xfer #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) u_xfer (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sio_busy  (sio_busy),
    .sio_latch (sio_latch),
    .done      (xfer_done),
    .fault     (fault)
  );

  assign wrap = (refresh_cnt == RW'(REFRESH_DIV - 1));

  // A new request wins over the IDLE clear so a pulse is never lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      refresh_cnt <= '0;
      pending     <= 1'b1;
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      if (wrap || update)               pending <= 1'b1;
      else if (state == IDLE && pending) pending <= 1'b0;
    end
  end

  // NOTE: snapshot data needs no reset; it is only read after a load.
  always_ff @(posedge clk) begin
    if (snap) begin
      seg_q    <= seg;
      led_q    <= led;
      bright_q <= brightness;
      on_q     <= display_on;
    end
  end

  always_comb begin
    disp_idx   = 4'(byte_idx - 5'd1);
    tx_byte    = 8'h00;
    last_idx   = 5'd0;
    next_group = IDLE;
`ifdef TM1638_KEY_SCAN_EN
    tx_rw      = (state != KEYS) || (byte_idx == 5'd0);
`endif
    case (state)
      MODE: begin
        tx_byte    = CMD_WRITE_AUTO;
        next_group = ADDR;
      end
      ADDR: begin
        last_idx   = 5'(NUM_DISP_BYTES);
        next_group = CTRL;
        if (byte_idx == 5'd0)  tx_byte = CMD_ADDR0;
        else if (disp_idx[0])  tx_byte = {7'b0, led_q[disp_idx[3:1]]};
        else                   tx_byte = seg_q[{disp_idx[3:1], 3'b000} +: 8];
      end
      CTRL: begin
        tx_byte = disp_ctrl_byte(on_q, bright_q);
`ifdef TM1638_KEY_SCAN_EN
        next_group = KEYS;
`else
        next_group = IDLE;
`endif
      end
      KEYS: begin
        last_idx = 5'(NUM_KEY_BYTES);
        tx_byte  = (byte_idx == 5'd0) ? CMD_READ_KEYS : 8'h00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state;
    gap_ret_d   = gap_ret;
    byte_idx_d  = byte_idx;
    gap_cnt_d   = gap_cnt;
    in_flight_d = in_flight;
    stb_d       = stb;
    busy_d      = ctrl_busy;
    wdata_d     = sio_wdata;
    start       = 1'b0;
    snap        = 1'b0;
`ifdef TM1638_KEY_SCAN_EN
    rw_d         = rw_q;
    key_shadow_d = key_shadow;
    keys_d       = keys;
    key_valid_d  = 1'b0;
    key_sel      = 2'(byte_idx - 5'd1);
`endif
    case (state)
      IDLE: begin
        if (pending) begin
          snap       = 1'b1;
          busy_d     = 1'b1;
          byte_idx_d = 5'd0;
          stb_d      = 1'b0;
          state_d    = MODE;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(STB_GAP - 1)) begin
          state_d = gap_ret;
          if (gap_ret == IDLE) busy_d = 1'b0;
          else                 stb_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: begin
        if (!in_flight) begin
          start       = 1'b1;
          in_flight_d = 1'b1;
          wdata_d     = tx_byte;
`ifdef TM1638_KEY_SCAN_EN
          rw_d        = tx_rw;
`endif
        end else if (xfer_done) begin
          in_flight_d = 1'b0;
`ifdef TM1638_KEY_SCAN_EN
          if (state == KEYS && byte_idx != 5'd0)
            key_shadow_d[{key_sel, 3'b000} +: 8] = sio_rdata;
`endif
          if (byte_idx == last_idx) begin
            state_d    = GAP;
            gap_ret_d  = next_group;
            gap_cnt_d  = '0;
            byte_idx_d = 5'd0;
            stb_d      = 1'b1;
`ifdef TM1638_KEY_SCAN_EN
            if (state == KEYS) begin
              keys_d      = key_shadow_d;
              key_valid_d = 1'b1;
            end
`endif
          end else begin
            byte_idx_d = byte_idx + 5'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gap_ret   <= IDLE;
      byte_idx  <= 5'd0;
      gap_cnt   <= '0;
      in_flight <= 1'b0;
      stb       <= 1'b1;
      sio_wdata <= 8'h00;
      ctrl_busy <= 1'b0;
    end else begin
      state     <= state_d;
      gap_ret   <= gap_ret_d;
      byte_idx  <= byte_idx_d;
      gap_cnt   <= gap_cnt_d;
      in_flight <= in_flight_d;
      stb       <= stb_d;
      sio_wdata <= wdata_d;
      ctrl_busy <= busy_d;
    end
  end

`ifdef TM1638_KEY_SCAN_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      rw_q       <= 1'b1;
      key_shadow <= '0;
      keys       <= '0;
      key_valid  <= 1'b0;
    end else begin
      rw_q       <= rw_d;
      key_shadow <= key_shadow_d;
      keys       <= keys_d;
      key_valid  <= key_valid_d;
    end
  end

  assign sio_rw = rw_q;
`else
  assign sio_rw    = 1'b1;
  assign keys      = '0;
  assign key_valid = 1'b0;
  wire   unused_rdata = ^sio_rdata;
`endif

endmodule
